// File: rtl/dcp_mshr_table.sv
// Miss-status holding register table for outstanding requests.
// Grants the lowest free ID, blocks same-line allocations, retires on response.
module dcp_mshr_table #(
  parameter int NUM_ENTRIES   = 8,
  parameter int MSHRID_WIDTH  = 8,
  parameter int PADDR_WIDTH   = 40,
  parameter int SIZE_WIDTH    = 3,
  parameter int HOMEID_WIDTH  = 14,
  parameter int REQTYPE_WIDTH = 8,
  parameter int LINE_OFFSET   = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alloc_valid,
  output logic                            alloc_ready,
  input  logic [PADDR_WIDTH-1:0]          alloc_paddr,
  input  logic [SIZE_WIDTH-1:0]           alloc_size,
  input  logic [HOMEID_WIDTH-1:0]         alloc_homeid,
  input  logic [REQTYPE_WIDTH-1:0]        alloc_type,
  output logic [MSHRID_WIDTH-1:0]         alloc_mshrid,
  input  logic                            resp_valid,
  input  logic [MSHRID_WIDTH-1:0]         resp_mshrid,
  output logic                            done_valid,
  output logic [MSHRID_WIDTH-1:0]         done_mshrid,
  output logic [PADDR_WIDTH-1:0]          done_paddr,
  output logic [SIZE_WIDTH-1:0]           done_size,
  output logic [HOMEID_WIDTH-1:0]         done_homeid,
  output logic [REQTYPE_WIDTH-1:0]        done_type,
  output logic [$clog2(NUM_ENTRIES+1)-1:0] occupancy,
  output logic                            full,
  output logic                            empty,
  output logic                            conflict,
  output logic                            err_bad_resp
);

  localparam int IDXW = $clog2(NUM_ENTRIES);
  localparam int OCCW = $clog2(NUM_ENTRIES + 1);

  logic [NUM_ENTRIES-1:0]   valid_q;
  logic [PADDR_WIDTH-1:0]   paddr_q  [NUM_ENTRIES];
  logic [SIZE_WIDTH-1:0]    size_q   [NUM_ENTRIES];
  logic [HOMEID_WIDTH-1:0]  homeid_q [NUM_ENTRIES];
  logic [REQTYPE_WIDTH-1:0] type_q   [NUM_ENTRIES];
  logic [OCCW-1:0]          occ_q;

  logic [IDXW-1:0] free_idx;
  logic [IDXW-1:0] resp_idx;
  logic            line_hit;
  logic            resp_in_range;
  logic            resp_legal;
  logic            alloc_fire;
  logic            occ_inc;
  logic            occ_dec;

  always_comb begin
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IDXW'(i);
    end
  end

  // Entries retiring this cycle still block their line until the edge.
  always_comb begin
    line_hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] &&
          paddr_q[i][PADDR_WIDTH-1:LINE_OFFSET] ==
          alloc_paddr[PADDR_WIDTH-1:LINE_OFFSET])
        line_hit = 1'b1;
    end
  end

  assign full         = (occ_q == OCCW'(NUM_ENTRIES));
  assign empty        = (occ_q == '0);
  assign occupancy    = occ_q;
  assign conflict     = alloc_valid && line_hit;
  assign alloc_ready  = !full && !conflict;
  assign alloc_mshrid = MSHRID_WIDTH'(free_idx);

  assign resp_in_range = {1'b0, resp_mshrid} <
                         (MSHRID_WIDTH + 1)'(NUM_ENTRIES);
  assign resp_idx      = resp_mshrid[IDXW-1:0];
  assign resp_legal    = resp_valid && resp_in_range &&
                         valid_q[resp_idx];
  assign alloc_fire    = !rst && alloc_valid && alloc_ready;
  assign occ_inc       = alloc_fire && !resp_legal;
  assign occ_dec       = resp_legal && !alloc_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      occ_q        <= '0;
      done_valid   <= 1'b0;
      err_bad_resp <= 1'b0;
    end else begin
      if (alloc_fire) valid_q[free_idx] <= 1'b1;
      if (resp_legal) valid_q[resp_idx] <= 1'b0;
      done_valid <= resp_legal;
      if (resp_valid && !resp_legal) err_bad_resp <= 1'b1;
      unique case (1'b1)
        occ_inc: occ_q <= occ_q + 1'b1;
        occ_dec: occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Payload carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      paddr_q[free_idx]  <= alloc_paddr;
      size_q[free_idx]   <= alloc_size;
      homeid_q[free_idx] <= alloc_homeid;
      type_q[free_idx]   <= alloc_type;
    end
    if (!rst && resp_legal) begin
      done_mshrid <= resp_mshrid;
      done_paddr  <= paddr_q[resp_idx];
      done_size   <= size_q[resp_idx];
      done_homeid <= homeid_q[resp_idx];
      done_type   <= type_q[resp_idx];
    end
  end

endmodule

// File: tb/tb_dcp_mshr_table.sv
// Bench for dcp_mshr_table: vector table, directed corners,
// and randomized traffic against an array-based reference model.
module tb_dcp_mshr_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [39:0] alloc_paddr;
  logic [2:0]  alloc_size;
  logic [13:0] alloc_homeid;
  logic [7:0]  alloc_type;
  logic [7:0]  alloc_mshrid;
  logic        resp_valid;
  logic [7:0]  resp_mshrid;
  logic        done_valid;
  logic [7:0]  done_mshrid;
  logic [39:0] done_paddr;
  logic [2:0]  done_size;
  logic [13:0] done_homeid;
  logic [7:0]  done_type;
  logic [3:0]  occupancy;
  logic        full;
  logic        empty;
  logic        conflict;
  logic        err_bad_resp;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dcp_mshr_table dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_paddr(alloc_paddr), .alloc_size(alloc_size),
    .alloc_homeid(alloc_homeid), .alloc_type(alloc_type),
    .alloc_mshrid(alloc_mshrid),
    .resp_valid(resp_valid), .resp_mshrid(resp_mshrid),
    .done_valid(done_valid), .done_mshrid(done_mshrid),
    .done_paddr(done_paddr), .done_size(done_size),
    .done_homeid(done_homeid), .done_type(done_type),
    .occupancy(occupancy), .full(full), .empty(empty),
    .conflict(conflict), .err_bad_resp(err_bad_resp)
  );

  typedef struct {
    bit          av;
    logic [39:0] pa;
    bit          rv;
    logic [7:0]  rid;
    bit          e_rdy;
    logic [7:0]  e_id;
    bit          e_cf;
    logic [3:0]  e_occ;
    bit          e_dv;
    logic [39:0] e_dpa;
    bit          e_err;
  } vec_t;

  vec_t vt[11];

  function automatic vec_t mk(
    bit av, logic [39:0] pa, bit rv, logic [7:0] rid,
    bit rdy, logic [7:0] id, bit cf, logic [3:0] occ,
    bit dv, logic [39:0] dpa, bit err);
    vec_t v;
    v.av = av; v.pa = pa; v.rv = rv; v.rid = rid;
    v.e_rdy = rdy; v.e_id = id; v.e_cf = cf; v.e_occ = occ;
    v.e_dv = dv; v.e_dpa = dpa; v.e_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input bit av, input logic [39:0] pa,
                       input bit rv, input logic [7:0] rid);
    alloc_valid = av;
    alloc_paddr = pa;
    resp_valid  = rv;
    resp_mshrid = rid;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 1'b0;
    resp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference model: per-ID occupancy and captured request.
  bit          m_busy [8];
  logic [39:0] m_pa   [8];
  logic [24:0] m_pay  [8];
  bit          m_err;

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m_busy[k] = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic run_random(input int cycles);
    bit          pend;
    logic [39:0] pa;
    logic [24:0] pay;
    pend = 1'b0;
    pa = '0;
    pay = '0;
    model_clear();
    for (int c = 0; c < cycles; c++) begin
      int          cnt;
      int          low;
      bit          hit;
      bit          av;
      bit          rv;
      bit          legal;
      bit          e_rdy;
      logic [7:0]  rid;
      if (c % 500 == 0) begin
        do_reset();
        model_clear();
        pend = 1'b0;
      end
      if (!pend && $urandom_range(0, 99) < 60) begin
        pend = 1'b1;
        pa = 40'h80_0000_0000 | (40'($urandom_range(0, 11)) << 6) |
             40'($urandom_range(0, 63));
        pay = 25'($urandom);
      end
      av = pend;
      rv = 1'b0;
      rid = '0;
      if ($urandom_range(0, 99) < 5) begin
        rv = 1'b1;
        rid = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 99) < 45) begin
        int st;
        st = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++) begin
          if (!rv && m_busy[(st + k) % 8]) begin
            rv = 1'b1;
            rid = 8'((st + k) % 8);
          end
        end
      end
      cnt = 0;
      low = -1;
      hit = 1'b0;
      for (int k = 7; k >= 0; k--) begin
        if (m_busy[k]) begin
          cnt++;
          if (m_pa[k][39:6] == pa[39:6]) hit = 1'b1;
        end else low = k;
      end
      e_rdy = (cnt < 8) && !(av && hit);
      legal = rv && rid < 8 && m_busy[rid[2:0]];
      {alloc_size, alloc_homeid, alloc_type} = pay;
      drive(av, pa, rv, rid);
      chk("rnd_ready", 64'(alloc_ready), 64'(e_rdy));
      chk("rnd_conflict", 64'(conflict), 64'(av && hit));
      if (low >= 0) chk("rnd_mshrid", 64'(alloc_mshrid), 64'(low));
      tick();
      if (legal) m_busy[rid[2:0]] = 1'b0;
      if (rv && !legal) m_err = 1'b1;
      if (av && e_rdy) begin
        m_busy[low] = 1'b1;
        m_pa[low] = pa;
        m_pay[low] = pay;
        pend = 1'b0;
        cnt++;
      end
      if (legal) begin
        cnt--;
        chk("rnd_done_paddr", 64'(done_paddr), 64'(m_pa[rid[2:0]]));
        chk("rnd_done_fields", 64'({done_size, done_homeid, done_type}),
            64'(m_pay[rid[2:0]]));
        chk("rnd_done_id", 64'(done_mshrid), 64'(rid));
      end
      chk("rnd_done_valid", 64'(done_valid), 64'(legal));
      chk("rnd_occupancy", 64'(occupancy), 64'(cnt));
      chk("rnd_err", 64'(err_bad_resp), 64'(m_err));
    end
  endtask

  initial begin
    alloc_paddr = '0;
    alloc_size = '0;
    alloc_homeid = '0;
    alloc_type = '0;
    resp_mshrid = '0;
    do_reset();
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_ready", 64'(alloc_ready), 64'd1);
    chk("rst_mshrid", 64'(alloc_mshrid), 64'd0);
    chk("rst_conflict", 64'(conflict), 64'd0);
    chk("rst_done", 64'(done_valid), 64'd0);
    chk("rst_err", 64'(err_bad_resp), 64'd0);

    vt[0]  = mk(1, 40'h1000, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    vt[1]  = mk(1, 40'h2000, 0, 0, 1, 1, 0, 2, 0, 0, 0);
    vt[2]  = mk(1, 40'h1020, 0, 0, 0, 2, 1, 2, 0, 0, 0);
    vt[3]  = mk(1, 40'h1020, 1, 0, 0, 2, 1, 1, 1, 40'h1000, 0);
    vt[4]  = mk(1, 40'h1020, 0, 0, 1, 0, 0, 2, 0, 0, 0);
    vt[5]  = mk(1, 40'h3000, 0, 0, 1, 2, 0, 3, 0, 0, 0);
    vt[6]  = mk(1, 40'h4000, 0, 0, 1, 3, 0, 4, 0, 0, 0);
    vt[7]  = mk(1, 40'h5000, 1, 1, 1, 4, 0, 4, 1, 40'h2000, 0);
    vt[8]  = mk(0, 40'h0, 1, 5, 1, 1, 0, 4, 0, 0, 1);
    vt[9]  = mk(0, 40'h0, 1, 9, 1, 1, 0, 4, 0, 0, 1);
    vt[10] = mk(0, 40'h0, 1, 0, 1, 1, 0, 3, 1, 40'h1020, 1);
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].av, vt[i].pa, vt[i].rv, vt[i].rid);
      chk($sformatf("vec%0d_ready", i), 64'(alloc_ready), 64'(vt[i].e_rdy));
      chk($sformatf("vec%0d_id", i), 64'(alloc_mshrid), 64'(vt[i].e_id));
      chk($sformatf("vec%0d_conf", i), 64'(conflict), 64'(vt[i].e_cf));
      tick();
      chk($sformatf("vec%0d_occ", i), 64'(occupancy), 64'(vt[i].e_occ));
      chk($sformatf("vec%0d_done", i), 64'(done_valid), 64'(vt[i].e_dv));
      if (vt[i].e_dv)
        chk($sformatf("vec%0d_dpa", i), 64'(done_paddr), 64'(vt[i].e_dpa));
      chk($sformatf("vec%0d_err", i), 64'(err_bad_resp), 64'(vt[i].e_err));
    end
    drive(0, 0, 0, 0);
    tick();
    chk("done_one_cycle", 64'(done_valid), 64'd0);

    // Full table: freed slot is granted only on the following cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 40'h10000 + 40'(i * 64), 0, 0);
      chk($sformatf("fill%0d_id", i), 64'(alloc_mshrid), 64'(i));
      tick();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_occ", 64'(occupancy), 64'd8);
    drive(1, 40'h20000, 0, 0);
    chk("full_ready", 64'(alloc_ready), 64'd0);
    tick();
    chk("full_no_alloc", 64'(occupancy), 64'd8);
    drive(1, 40'h20000, 1, 3);
    chk("free_same_cyc_ready", 64'(alloc_ready), 64'd0);
    tick();
    chk("free_done", 64'(done_valid), 64'd1);
    chk("free_dpa", 64'(done_paddr), 64'h100c0);
    chk("free_occ", 64'(occupancy), 64'd7);
    chk("free_full", 64'(full), 64'd0);
    drive(1, 40'h20000, 0, 0);
    chk("regrant_ready", 64'(alloc_ready), 64'd1);
    chk("regrant_id", 64'(alloc_mshrid), 64'd3);
    tick();
    chk("regrant_occ", 64'(occupancy), 64'd8);

    // Reset discards live entries, pending response and sticky error.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 40'h1000 + 40'(i * 64), 0, 0);
      tick();
    end
    drive(0, 0, 1, 9);
    tick();
    chk("pre_rst_err", 64'(err_bad_resp), 64'd1);
    rst = 1'b1;
    drive(1, 40'h9000, 1, 0);
    tick();
    rst = 1'b0;
    chk("midrst_empty", 64'(empty), 64'd1);
    chk("midrst_done", 64'(done_valid), 64'd0);
    chk("midrst_err", 64'(err_bad_resp), 64'd0);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    drive(1, 40'h1000, 0, 0);
    chk("postrst_conflict", 64'(conflict), 64'd0);
    chk("postrst_ready", 64'(alloc_ready), 64'd1);
    chk("postrst_id", 64'(alloc_mshrid), 64'd0);
    tick();

    run_random(4000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcp_mshr_table.md
DCP_MSHR_TABLE -- requirements
Module: dcp_mshr_table

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of outstanding-request entries, range 2..256.
REQ-002 SHALL have parameter MSHRID_WIDTH, default 8: ID width, with NUM_ENTRIES <= 2**MSHRID_WIDTH.
REQ-003 SHALL have parameter PADDR_WIDTH, default 40: physical address width.
REQ-004 SHALL have parameters SIZE_WIDTH (default 3), HOMEID_WIDTH (default 14), REQTYPE_WIDTH (default 8): stored request fields.
REQ-005 SHALL have parameter LINE_OFFSET, default 6: low paddr bits ignored by the conflict check.
REQ-006 SHALL have port: clk  in  1  clock; all state changes on the rising edge.
REQ-007 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-008 SHALL have ports: alloc_valid in 1; alloc_ready out 1; alloc_paddr in PADDR_WIDTH; alloc_size in SIZE_WIDTH; alloc_homeid in HOMEID_WIDTH; alloc_type in REQTYPE_WIDTH.
REQ-009 SHALL have port: alloc_mshrid  out  MSHRID_WIDTH  ID granted this cycle.
REQ-010 SHALL have ports: resp_valid in 1; resp_mshrid in MSHRID_WIDTH (response returning an entry).
REQ-011 SHALL have ports: done_valid out 1; done_mshrid out MSHRID_WIDTH; done_paddr out PADDR_WIDTH; done_size out SIZE_WIDTH; done_homeid out HOMEID_WIDTH; done_type out REQTYPE_WIDTH.
REQ-012 SHALL have ports: occupancy out $clog2(NUM_ENTRIES+1); full out 1; empty out 1; conflict out 1; err_bad_resp out 1.

Function
REQ-013 SHALL keep per entry a valid bit plus stored paddr, size, homeid and type.
REQ-014 SHALL drive alloc_mshrid combinationally to the lowest-index invalid entry, zero-extended to MSHRID_WIDTH.
REQ-015 SHALL drive conflict high when alloc_valid=1 and alloc_paddr[PADDR_WIDTH-1:LINE_OFFSET] equals that field of any valid entry.
REQ-016 SHALL assert alloc_ready = !full && !conflict, with no dependence on resp_valid in the same cycle.
REQ-017 SHALL, on alloc_valid && alloc_ready, set the chosen entry valid and capture its fields at the clock edge.
REQ-018 SHALL treat a response as legal when resp_valid=1, resp_mshrid < NUM_ENTRIES, and that entry is valid.
REQ-019 SHALL, on a legal response, clear the entry's valid bit at the edge and, in the same edge, register done_valid=1, done_mshrid and the stored fields (one-cycle latency).
REQ-020 SHALL hold done_valid high for exactly one cycle per legal response; the done_* fields are don't-care while done_valid=0.
REQ-021 SHALL, on an illegal response, change no entry, leave done_valid at 0, and set sticky err_bad_resp=1 until reset.
REQ-022 SHALL, on simultaneous allocation and legal response in one cycle, perform both; an entry freed that cycle is not allocatable until the next cycle, and its line does not remove conflict until the next cycle.
REQ-023 SHALL keep occupancy as the registered valid-entry count: +1 on allocation only, -1 on legal response only, unchanged when both or neither occur.
REQ-024 SHALL derive full = (occupancy == NUM_ENTRIES) and empty = (occupancy == 0).
REQ-025 SHALL not update any entry when alloc_valid=1 and alloc_ready=0; the requester holds its inputs stable until accepted.

Reset
REQ-026 SHALL, while rst=1 at an edge, clear all valid bits, occupancy and err_bad_resp, and set done_valid=0.
REQ-027 SHALL, while rst=1, ignore alloc and resp inputs; an operation in flight is discarded.
REQ-028 SHALL have empty=1, full=0 and alloc_ready=1 in the first cycle after reset, with alloc_mshrid=0 and no conflict.
REQ-029 SHALL not reset stored payload fields.

Verification
REQ-030 SHALL pass this directed case: reset, then alloc paddr 0x1000 -> mshrid 0 granted, occupancy 1; then alloc 0x2000 -> mshrid 1.
REQ-031 SHALL pass this directed case: with 0x1000 outstanding, alloc 0x1020 -> conflict=1, alloc_ready=0; resp mshrid 0 -> next cycle done_valid=1 with done_paddr 0x1000; one cycle later 0x1020 is accepted.
REQ-032 SHALL pass this directed case: fill 8 entries -> full=1, alloc_ready=0; resp mshrid 3 together with a pending alloc -> alloc not accepted that cycle, accepted next cycle with mshrid 3.
REQ-033 SHALL pass this directed case: at occupancy 4, alloc and legal resp in the same cycle -> occupancy stays 4, both take effect.
REQ-034 SHALL pass this directed case: resp mshrid 5 while entry 5 is invalid, and resp mshrid 9 with NUM_ENTRIES=8 -> err_bad_resp=1, no done_valid, occupancy unchanged.
REQ-035 SHALL pass this directed case: rst asserted with 3 entries valid and a resp pending -> next cycle empty=1, done_valid=0, err_bad_resp=0.
